// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART codebase slice.
//   - cap_state_t : receive-capture FSM state encoding (exported on the
//                   uart_rx_fifo debug port so checkers can bind to it)
//   - ADDR_*      : memory-mapped UART register address map
//   - SETUP_*_BIT : status bit positions inside the setup/status register
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_ACK  = 2'd1,
        CAP_WAIT = 2'd2
    } cap_state_t;

    // Register address map (word offsets in the UART register block).
    localparam logic [1:0] ADDR_BYTE_RATE = 2'd0;
    localparam logic [1:0] ADDR_TX_DATA   = 2'd1;
    localparam logic [1:0] ADDR_RX_DATA   = 2'd2;
    localparam logic [1:0] ADDR_SETUP     = 2'd3;

    // Status bits reported in the setup register.
    localparam int SETUP_RX_EMPTY_BIT = 0;
    localparam int SETUP_RX_FULL_BIT  = 1;
    localparam int SETUP_RX_OVF_BIT   = 2;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the receiver-side and CPU-side signals of uart_rx_fifo.
//   slave  : the FIFO itself
//   master : whoever drives it (receiver core + register block, or a bench)
// Receiver handshake: rx_flag is a level held high by the receiver while a
// byte is pending (rx_data/rx_parity stable); the FIFO answers with a single
// one-cycle rx_flag_clr pulse after capturing the byte, and captures nothing
// more until rx_flag has returned low.
// CPU side: rd_data/rd_perr always show the head entry (first-word fall-
// through); rd_en pops it on the next clock edge when empty is low.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              rx_flag;
    logic [DATA_W-1:0] rx_data;
    logic              rx_parity;
    logic              rx_flag_clr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              ovf_clr;

    modport slave (
        input  rx_flag, rx_data, rx_parity, rd_en, ovf_clr,
        output rx_flag_clr, rd_data, rd_perr, empty, full, count, overflow
    );

    modport master (
        output rx_flag, rx_data, rx_parity, rd_en, ovf_clr,
        input  rx_flag_clr, rd_data, rd_perr, empty, full, count, overflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x W register array: synchronous write, asynchronous read.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational)
// Contents are not reset; the owner gates the read path with its own
// empty status.
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer between the UART receiver core and the register block.
// Captures every byte the receiver flags, acknowledges it with a one-cycle
// rx_flag_clr, and queues it in a first-word-fall-through FIFO.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous, active-high reset
//   bus       slave modport of uart_rx_fifo_if (receiver + CPU signals)
//   cap_state out  capture FSM state (debug visibility)
// Optional feature macro: UART_RX_FIFO_PARITY_EN
//   defined     : entries carry an extra parity-error bit,
//                 perr = ^{rx_data, rx_parity} (even parity), shown on rd_perr
//   not defined : entries are DATA_W bits, rx_parity ignored, rd_perr = 0
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_fifo_if.slave        bus,
    output cap_state_t           cap_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef UART_RX_FIFO_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    cap_state_t         state_q;
    logic               clr_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;

    logic               empty_w;
    logic               full_w;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               ovf_set;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CNT_W'(DEPTH));

    // A capture is attempted only from IDLE, so a held rx_flag yields one push.
    assign push_req = (state_q == CAP_IDLE) && bus.rx_flag;
    assign pop      = bus.rd_en && !empty_w;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req && (!full_w || pop);
    assign ovf_set  = push_req && full_w && !pop;

`ifdef UART_RX_FIFO_PARITY_EN
    assign wr_entry    = {^{bus.rx_data, bus.rx_parity}, bus.rx_data};
    assign bus.rd_perr = empty_w ? 1'b0 : rd_entry[DATA_W];
`else
    assign wr_entry    = bus.rx_data;
    assign bus.rd_perr = 1'b0;
`endif

    assign bus.rd_data     = empty_w ? '0 : rd_entry[DATA_W-1:0];
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.rx_flag_clr = clr_q;
    assign cap_state       = state_q;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Capture FSM. rx_flag_clr is registered and high exactly while in ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAP_IDLE;
            clr_q   <= 1'b0;
        end else begin
            case (state_q)
                CAP_IDLE: begin
                    clr_q <= 1'b0;
                    if (bus.rx_flag) begin
                        state_q <= CAP_ACK;
                        clr_q   <= 1'b1;
                    end
                end
                CAP_ACK: begin
                    state_q <= CAP_WAIT;
                    clr_q   <= 1'b0;
                end
                CAP_WAIT: begin
                    clr_q <= 1'b0;
                    if (!bus.rx_flag) begin
                        state_q <= CAP_IDLE;
                    end
                end
                default: begin
                    state_q <= CAP_IDLE;
                    clr_q   <= 1'b0;
                end
            endcase
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Set has priority over a simultaneous clear.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule
